// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the combinational ALU and its command
//               sequencer: operation codes, issue order, sequencer states.
// Contents    : ALU_* code constants, OP_COUNT, idx_to_code(), seq_state_e
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  localparam int         OP_COUNT = 7;
  localparam logic [2:0] LAST_IDX = 3'(OP_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Fixed issue order; idx 7 is never reached and falls back to ADD.
  function automatic logic [3:0] idx_to_code(input logic [2:0] idx);
    logic [3:0] code;
    case (idx)
      3'd0:    code = ALU_ADD;
      3'd1:    code = ALU_SUB;
      3'd2:    code = ALU_SHL;
      3'd3:    code = ALU_SHR;
      3'd4:    code = ALU_AND;
      3'd5:    code = ALU_OR;
      3'd6:    code = ALU_XOR;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : On an accepted start, latches operands A/B and walks every
//               supported ALU operation in fixed order. ALU inputs are driven
//               from registers; each result/flag pair is captured one cycle
//               later and offered as a tagged beat on a valid/ready port.
// Ports       : clk_i, rst_ni          clock / async active-low reset
//               start_i, abort_i       sequence control
//               op_a_i, op_b_i         operands, latched on accepted start
//               busy_o, done_o         status (done pulses after last beat)
//               alu_code_o/a_o/b_o     registered ALU command
//               alu_result_i/flags_i   combinational ALU response
//               res_valid_o/ready_i    result handshake
//               res_code_o/value_o/flags_o  result beat payload
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [BITS-1:0] op_a_i,
  input  logic [BITS-1:0] op_b_i,
  output logic            busy_o,
  output logic [3:0]      alu_code_o,
  output logic [BITS-1:0] alu_a_o,
  output logic [BITS-1:0] alu_b_o,
  input  logic [BITS-1:0] alu_result_i,
  input  logic [3:0]      alu_flags_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [3:0]      res_code_o,
  output logic [BITS-1:0] res_value_o,
  output logic [3:0]      res_flags_o,
  output logic            done_o
);

  seq_state_e      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      alu_code_q, alu_code_d;
  logic [BITS-1:0] alu_a_q, alu_a_d;
  logic [BITS-1:0] alu_b_q, alu_b_d;
  logic            res_valid_q, res_valid_d;
  logic [3:0]      res_code_q, res_code_d;
  logic [BITS-1:0] res_value_q, res_value_d;
  logic [3:0]      res_flags_q, res_flags_d;

  logic w_handshake;
  logic w_abort;

  assign w_handshake = res_valid_q & res_ready_i;
  // Abort only has meaning once a sequence is running.
  assign w_abort     = abort_i & (state_q != IDLE);

  // --------------------------------------------------------------------------
  // State register plus the datapath registers it sequences
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      alu_code_q  <= ALU_ADD;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_code_q  <= 4'b0000;
      res_value_q <= '0;
      res_flags_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      alu_code_q  <= alu_code_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_code_q  <= res_code_d;
      res_value_q <= res_value_d;
      res_flags_q <= res_flags_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (w_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i && !abort_i) state_d = ISSUE;
        ISSUE:   state_d = WAIT;
        WAIT:    if (w_handshake) state_d = (idx_q == LAST_IDX) ? DONE : ISSUE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    idx_d       = idx_q;
    alu_code_d  = alu_code_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_code_d  = res_code_q;
    res_value_d = res_value_q;
    res_flags_d = res_flags_q;

    if (w_abort) begin
      // Any pending beat is dropped, even if it is being accepted right now.
      idx_d       = 3'd0;
      alu_code_d  = ALU_ADD;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            idx_d      = 3'd0;
            alu_code_d = idx_to_code(3'd0);
            alu_a_d    = op_a_i;
            alu_b_d    = op_b_i;
          end
        end
        ISSUE: begin
          // ALU inputs have been stable for a full cycle; capture its output.
          res_value_d = alu_result_i;
          res_flags_d = alu_flags_i;
          res_code_d  = alu_code_q;
          res_valid_d = 1'b1;
        end
        WAIT: begin
          if (w_handshake) begin
            res_valid_d = 1'b0;
            if (idx_q != LAST_IDX) begin
              idx_d      = idx_q + 3'd1;
              alu_code_d = idx_to_code(idx_q + 3'd1);
            end
          end
        end
        DONE: begin
          // Operands are left in place; only the code returns to its idle value.
          idx_d      = 3'd0;
          alu_code_d = ALU_ADD;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
    alu_code_o  = alu_code_q;
    alu_a_o     = alu_a_q;
    alu_b_o     = alu_b_q;
    res_valid_o = res_valid_q;
    res_code_o  = res_code_q;
    res_value_o = res_value_q;
    res_flags_o = res_flags_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer with a behavioural
//               ALU alongside and a beat-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int BITS = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, abort;
  logic [BITS-1:0] op_a, op_b;
  logic            busy;
  logic [3:0]      alu_code;
  logic [BITS-1:0] alu_a, alu_b;
  logic [BITS-1:0] alu_result;
  logic [3:0]      alu_flags;
  logic            res_valid, res_ready;
  logic [3:0]      res_code;
  logic [BITS-1:0] res_value;
  logic [3:0]      res_flags;
  logic            done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.BITS(BITS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .busy_o       (busy),
    .alu_code_o   (alu_code),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_result_i (alu_result),
    .alu_flags_i  (alu_flags),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_code_o   (res_code),
    .res_value_o  (res_value),
    .res_flags_o  (res_flags),
    .done_o       (done)
  );

  // Behavioural ALU; unknown codes give an obviously wrong pattern.
  always_comb begin
    case (alu_code)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0100: alu_result = alu_a << 1;
      4'b0101: alu_result = alu_a >> 1;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = 4'b1011;
    endcase
    alu_flags = {alu_result == 4'd0, alu_result[BITS-1], alu_a[0], alu_b[0]};
  end

  // Reference: the k-th beat of a sequence started with operands a/b.
  function automatic logic [3:0] ref_code(input int k);
    logic [3:0] order [OP_COUNT];
    order = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
    return order[k];
  endfunction

  function automatic logic [BITS-1:0] ref_value(input int k, input logic [BITS-1:0] a, b);
    int m, r;
    m = 1 << BITS;
    case (k)
      0:       r = (int'(a) + int'(b)) % m;
      1:       r = (int'(a) - int'(b) + m) % m;
      2:       r = (int'(a) * 2) % m;
      3:       r = int'(a) / 2;
      4:       r = int'(a & b);
      5:       r = int'(a | b);
      default: r = int'(a ^ b);
    endcase
    return BITS'(r);
  endfunction

  function automatic logic [3:0] ref_flags(input logic [BITS-1:0] v, a, b);
    return {v == '0, v[BITS-1], a[0], b[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one sequence from IDLE. stall_beat/stall_len force res_ready low;
  // start_beat re-pulses start (with other operands) in that beat's WAIT;
  // abort_beat aborts while that beat is being accepted. -1 disables.
  task automatic run_seq(input logic [BITS-1:0] a, b, input bit rand_ready,
                         input int stall_beat, stall_len, start_beat, abort_beat,
                         output int done_cyc);
    int k, cyc, exp_valid, stalled;
    logic [BITS-1:0] v;
    done_cyc = -1;
    chk("idle_busy", busy, 1'b0);
    op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = BITS'($urandom); op_b = BITS'($urandom);
    cyc = 1; k = 0; exp_valid = 2; stalled = 0;
    while (k < OP_COUNT && cyc < 200) begin
      chk("run_busy", busy, 1'b1);
      chk("run_done", done, 1'b0);
      if (cyc < exp_valid) begin
        chk("issue_valid", res_valid, 1'b0);
        if (cyc == exp_valid - 1) begin
          chk("issue_code", alu_code, ref_code(k));
          chk("issue_a", alu_a, a);
          chk("issue_b", alu_b, b);
        end
        res_ready = 1'($urandom_range(0, 1));
      end else begin
        v = ref_value(k, a, b);
        chk("beat_valid", res_valid, 1'b1);
        chk("beat_code", res_code, ref_code(k));
        chk("beat_value", res_value, v);
        chk("beat_flags", res_flags, ref_flags(v, a, b));
        if (k == stall_beat && stalled < stall_len) begin
          res_ready = 1'b0;
          stalled++;
        end else begin
          res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (k == abort_beat) begin
          res_ready = 1'b1;
          abort = 1'b1;
          tick();
          abort = 1'b0;
          chk("abort_busy", busy, 1'b0);
          chk("abort_valid", res_valid, 1'b0);
          chk("abort_done", done, 1'b0);
          chk("abort_code", alu_code, 4'b0000);
          tick();
          chk("abort_done2", done, 1'b0);
          chk("abort_busy2", busy, 1'b0);
          return;
        end
        if (k == start_beat && cyc == exp_valid) begin
          start = 1'b1;
          op_a = ~a; op_b = a ^ b ^ 4'b0101;
        end
        if (res_ready) begin
          k++;
          exp_valid = cyc + 2;
        end
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk("beat_count", k, OP_COUNT);
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("done_valid", res_valid, 1'b0);
    done_cyc = cyc;
    res_ready = 1'b0;
    tick();
    chk("post_done", done, 1'b0);
    chk("post_busy", busy, 1'b0);
    chk("post_code", alu_code, 4'b0000);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_valid"}, res_valid, 1'b0);
    chk({tag, "_done"},  done, 1'b0);
    chk({tag, "_code"},  alu_code, 4'b0000);
    chk({tag, "_a"},     alu_a, '0);
    chk({tag, "_b"},     alu_b, '0);
    chk({tag, "_rcode"}, res_code, 4'b0000);
    chk({tag, "_rval"},  res_value, '0);
    chk({tag, "_rflg"},  res_flags, 4'b0000);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Basic sequence, ready tied high: done in cycle 15.
    run_seq(4'b0110, 4'b0011, 1'b0, -1, 0, -1, -1, dc);
    chk("t1_done_cycle", dc, 15);

    // Wrap-around cases.
    run_seq(4'b1111, 4'b0001, 1'b0, -1, 0, -1, -1, dc);
    run_seq(4'b0000, 4'b0001, 1'b0, -1, 0, -1, -1, dc);

    // Three stall cycles on the shl beat push done to cycle 18.
    run_seq(4'b0110, 4'b0011, 1'b0, 2, 3, -1, -1, dc);
    chk("t3_done_cycle", dc, 18);

    // Start during WAIT of beat 4 is ignored.
    run_seq(4'b1001, 4'b0110, 1'b0, -1, 0, 4, -1, dc);
    chk("t4_done_cycle", dc, 15);

    // Abort on beat 3 with the handshake happening, then a clean restart.
    run_seq(4'b0101, 4'b1100, 1'b0, -1, 0, -1, 3, dc);
    run_seq(4'b0011, 4'b1010, 1'b0, -1, 0, -1, -1, dc);

    // Asynchronous reset mid-ISSUE.
    op_a = 4'b1101; op_b = 4'b0111; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    tick();
    chk_all_zero("rst_held");
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_seq(4'b1101, 4'b0111, 1'b0, -1, 0, -1, -1, dc);

    // Random operands with random backpressure.
    for (int i = 0; i < 6; i++) begin
      run_seq(BITS'($urandom), BITS'($urandom), 1'b1, -1, 0, -1, -1, dc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
